// File: rtl/pc_pkg.sv
// Shared types and constants for the program-counter sequencer.
package pc_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'b00,
        RUN  = 2'b01,
        HALT = 2'b10
    } pc_state_e;

    localparam int unsigned INSN_BYTES  = 32'd4;
    localparam int unsigned JREGION_LSB = 32'd28;

    // Instruction fetch addresses must land on a word boundary.
    function automatic logic is_misaligned(input logic [1:0] low_bits);
        return (low_bits != 2'b00);
    endfunction

endpackage

// File: rtl/pc_incr_adder.sv
// Parametrised address adder; used for both pc+4 and the branch target.
module pc_incr_adder
    import pc_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] a,
    input  logic [ADDR_W-1:0] b,
    output logic [ADDR_W-1:0] sum
);

    // Modulo 2^ADDR_W addition; carry out is intentionally discarded.
    assign sum = a + b;

endmodule

// File: rtl/pc_sequencer.sv
// Registered program counter with BOOT/RUN/HALT control, prioritised
// next-PC selection and sticky misalignment detection.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int unsigned ADDR_W    = 32,
    parameter logic [31:0] RESET_VEC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              halt,
    input  logic              resume,
    input  logic              branch_taken,
    input  logic [15:0]       branch_imm,
    input  logic              jump,
    input  logic [25:0]       jump_idx,
    input  logic              jr,
    input  logic [ADDR_W-1:0] jr_addr,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic              pc_valid,
    output logic              redirect,
    output logic              misalign_err
);

    localparam logic [ADDR_W-1:0] RESET_PC = RESET_VEC[ADDR_W-1:0];

    pc_state_e         state_r;
    pc_state_e         state_next_s;
    logic [ADDR_W-1:0] pc_r;
    logic [ADDR_W-1:0] pc_next_s;
    logic              pc_valid_r;
    logic              pc_valid_next_s;
    logic              redirect_r;
    logic              redirect_next_s;
    logic              misalign_err_r;
    logic              misalign_set_s;

    logic [ADDR_W-1:0] pc_plus4_s;
    logic [ADDR_W-1:0] branch_off_s;
    logic [ADDR_W-1:0] branch_target_s;
    logic [ADDR_W-1:0] jump_target_s;
    logic [ADDR_W-1:0] jr_target_s;

    pc_incr_adder #(.ADDR_W(ADDR_W)) u_plus4_adder (
        .a   (pc_r),
        .b   (ADDR_W'(INSN_BYTES)),
        .sum (pc_plus4_s)
    );

    // Word offset scaled to bytes and sign-extended to the PC width.
    assign branch_off_s = {{(ADDR_W-18){branch_imm[15]}}, branch_imm, 2'b00};

    pc_incr_adder #(.ADDR_W(ADDR_W)) u_branch_adder (
        .a   (pc_plus4_s),
        .b   (branch_off_s),
        .sum (branch_target_s)
    );

    // The jump keeps the current 256 MiB region; with a 28-bit PC there is no region.
    generate
        if (ADDR_W > JREGION_LSB) begin : g_jump_region
            assign jump_target_s = {pc_plus4_s[ADDR_W-1:JREGION_LSB], jump_idx, 2'b00};
        end else begin : g_jump_flat
            assign jump_target_s = {jump_idx, 2'b00};
        end
    endgenerate

    assign jr_target_s = {jr_addr[ADDR_W-1:2], 2'b00};

    // Next-state, next-PC and status flag selection.
    always_comb begin
        state_next_s    = state_r;
        pc_next_s       = pc_r;
        pc_valid_next_s = 1'b0;
        redirect_next_s = 1'b0;
        misalign_set_s  = 1'b0;
        case (state_r)
            BOOT: begin
                state_next_s    = RUN;
                pc_valid_next_s = 1'b1;
            end
            RUN: begin
                if (stall) begin
                    pc_next_s = pc_r;
                end else if (jr) begin
                    pc_next_s       = jr_target_s;
                    redirect_next_s = 1'b1;
                    misalign_set_s  = is_misaligned(jr_addr[1:0]);
                end else if (jump) begin
                    pc_next_s       = jump_target_s;
                    redirect_next_s = 1'b1;
                end else if (branch_taken) begin
                    pc_next_s       = branch_target_s;
                    redirect_next_s = 1'b1;
                end else begin
                    pc_next_s = pc_plus4_s;
                end
                // The update above still lands on the edge that enters HALT.
                if (halt) begin
                    state_next_s    = HALT;
                    pc_valid_next_s = 1'b0;
                end else begin
                    state_next_s    = RUN;
                    pc_valid_next_s = 1'b1;
                end
            end
            HALT: begin
                if (resume) begin
                    state_next_s    = RUN;
                    pc_valid_next_s = 1'b1;
                end else begin
                    state_next_s    = HALT;
                    pc_valid_next_s = 1'b0;
                end
            end
            default: begin
                state_next_s    = BOOT;
                pc_valid_next_s = 1'b0;
            end
        endcase
    end

    // State, PC and status registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r        <= BOOT;
            pc_r           <= RESET_PC;
            pc_valid_r     <= 1'b0;
            redirect_r     <= 1'b0;
            misalign_err_r <= 1'b0;
        end else begin
            state_r        <= state_next_s;
            pc_r           <= pc_next_s;
            pc_valid_r     <= pc_valid_next_s;
            redirect_r     <= redirect_next_s;
            misalign_err_r <= misalign_err_r | misalign_set_s;
        end
    end

    assign pc           = pc_r;
    assign pc_plus4     = pc_plus4_s;
    assign pc_valid     = pc_valid_r;
    assign redirect     = redirect_r;
    assign misalign_err = misalign_err_r;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed and randomized checks of pc_sequencer against a behavioural model.
module tb_pc_sequencer;

    localparam logic [31:0] RV = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, halt, resume, branch_taken, jump, jr;
    logic [15:0] branch_imm;
    logic [25:0] jump_idx;
    logic [31:0] jr_addr;
    logic [31:0] pc, pc_plus4;
    logic        pc_valid, redirect, misalign_err;

    int checks = 0;
    int errors = 0;

    // Reference model: mode 0 = booting, 1 = running, 2 = halted.
    int          m_mode;
    logic [31:0] m_pc;
    logic        m_valid, m_redir, m_err;

    pc_sequencer #(.ADDR_W(32), .RESET_VEC(RV)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall        (stall),
        .halt         (halt),
        .resume       (resume),
        .branch_taken (branch_taken),
        .branch_imm   (branch_imm),
        .jump         (jump),
        .jump_idx     (jump_idx),
        .jr           (jr),
        .jr_addr      (jr_addr),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .pc_valid     (pc_valid),
        .redirect     (redirect),
        .misalign_err (misalign_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        stall = 1'b0; halt = 1'b0; resume = 1'b0;
        branch_taken = 1'b0; jump = 1'b0; jr = 1'b0;
        branch_imm = 16'h0000; jump_idx = 26'h0; jr_addr = 32'h0;
    endtask

    task automatic model_edge();
        int          off;
        logic [31:0] seq;
        if (!rst_n) begin
            m_mode = 0; m_pc = RV; m_valid = 1'b0; m_redir = 1'b0; m_err = 1'b0;
        end else if (m_mode == 0) begin
            m_mode = 1; m_valid = 1'b1; m_redir = 1'b0;
        end else if (m_mode == 2) begin
            m_redir = 1'b0;
            if (resume) m_mode = 1;
            m_valid = (m_mode == 1);
        end else begin
            seq = m_pc + 32'd4;
            m_redir = !stall && (jr || jump || branch_taken);
            if (stall) begin
                m_pc = m_pc;
            end else if (jr) begin
                m_pc = jr_addr & 32'hFFFF_FFFC;
                if (jr_addr % 4 != 0) m_err = 1'b1;
            end else if (jump) begin
                m_pc = (seq & 32'hF000_0000) + 32'(jump_idx) * 32'd4;
            end else if (branch_taken) begin
                off = $signed(branch_imm);
                m_pc = seq + 32'(off * 4);
            end else begin
                m_pc = seq;
            end
            if (halt) m_mode = 2;
            m_valid = (m_mode == 1);
        end
    endtask

    task automatic compare_all(input string tag);
        check_eq({tag, ".pc"}, pc, m_pc);
        check_eq({tag, ".pc_plus4"}, pc_plus4, m_pc + 32'd4);
        check_eq({tag, ".pc_valid"}, 32'(pc_valid), 32'(m_valid));
        check_eq({tag, ".redirect"}, 32'(redirect), 32'(m_redir));
        check_eq({tag, ".misalign_err"}, 32'(misalign_err), 32'(m_err));
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        compare_all(tag);
    endtask

    task automatic do_jr(input logic [31:0] target);
        clear_inputs();
        jr = 1'b1; jr_addr = target;
        step("setup_jr");
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        m_mode = 0; m_pc = RV; m_valid = 1'b0; m_redir = 1'b0; m_err = 1'b0;

        // Reset and boot sequence.
        for (int i = 0; i < 3; i++) step("reset");
        check_eq("reset_pc", pc, 32'h0040_0000);
        check_eq("reset_valid", 32'(pc_valid), 32'd0);
        check_eq("reset_plus4", pc_plus4, 32'h0040_0004);
        rst_n = 1'b1;
        step("boot");
        check_eq("first_fetch_pc", pc, 32'h0040_0000);
        check_eq("first_fetch_valid", 32'(pc_valid), 32'd1);
        step("seq");
        check_eq("second_fetch_pc", pc, 32'h0040_0004);

        // Priority: jr beats jump and branch; stall beats everything.
        do_jr(32'h0000_0100);
        jr = 1'b1; jr_addr = 32'h0000_2000; jump = 1'b1; jump_idx = 26'h3FF; branch_taken = 1'b1;
        step("prio");
        check_eq("prio_pc", pc, 32'h0000_2000);
        check_eq("prio_redirect", 32'(redirect), 32'd1);
        do_jr(32'h0000_0100);
        stall = 1'b1; jr = 1'b1; jr_addr = 32'h0000_2000; jump = 1'b1; branch_taken = 1'b1;
        step("stall");
        check_eq("stall_pc", pc, 32'h0000_0100);
        check_eq("stall_redirect", 32'(redirect), 32'd0);
        clear_inputs();

        // Branch with offset -1 word lands back on the branch itself.
        branch_taken = 1'b1; branch_imm = 16'hFFFF;
        step("branch");
        check_eq("branch_back_pc", pc, 32'h0000_0100);
        clear_inputs();

        // Sequential wrap-around at the top of the address space.
        do_jr(32'hFFFF_FFFC);
        step("wrap");
        check_eq("wrap_pc", pc, 32'h0000_0000);

        // Jump keeps the upper region bits.
        do_jr(32'h9000_0000);
        jump = 1'b1; jump_idx = 26'h000_0010;
        step("jump");
        check_eq("jump_pc", pc, 32'h9000_0040);
        clear_inputs();

        // Misaligned register jump: aligned load and a sticky error.
        do_jr(32'h0000_1003);
        check_eq("misalign_pc", pc, 32'h0000_1000);
        check_eq("misalign_err", 32'(misalign_err), 32'd1);
        for (int i = 0; i < 4; i++) step("after_misalign");
        check_eq("misalign_sticky", 32'(misalign_err), 32'd1);

        // Halt and resume.
        do_jr(32'h0000_0200);
        halt = 1'b1;
        step("halt");
        check_eq("halt_pc", pc, 32'h0000_0204);
        check_eq("halt_valid", 32'(pc_valid), 32'd0);
        clear_inputs();
        jr = 1'b1; jr_addr = 32'h0000_4000; branch_taken = 1'b1;
        step("halted_ignore");
        check_eq("halted_pc", pc, 32'h0000_0204);
        clear_inputs();
        halt = 1'b1; resume = 1'b1;
        step("resume");
        check_eq("resume_valid", 32'(pc_valid), 32'd1);
        clear_inputs();
        step("post_resume");
        check_eq("resume_pc", pc, 32'h0000_0208);

        // Randomized traffic with occasional mid-run resets.
        for (int i = 0; i < 3000; i++) begin
            rst_n        = ($urandom_range(0, 149) != 0);
            stall        = ($urandom_range(0, 4) == 0);
            jr           = ($urandom_range(0, 5) == 0);
            jump         = ($urandom_range(0, 5) == 0);
            branch_taken = ($urandom_range(0, 3) == 0);
            halt         = ($urandom_range(0, 19) == 0);
            resume       = ($urandom_range(0, 2) == 0);
            jr_addr      = $urandom;
            jump_idx     = 26'($urandom);
            branch_imm   = 16'($urandom);
            step("rand");
        end

        // Only reset clears the sticky error.
        clear_inputs();
        rst_n = 1'b1;
        do_jr(32'h0000_0001);
        check_eq("err_before_reset", 32'(misalign_err), 32'd1);
        rst_n = 1'b0;
        step("final_reset");
        check_eq("err_cleared", 32'(misalign_err), 32'd0);
        check_eq("final_reset_pc", pc, 32'h0040_0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
